synchronous_fifo_flags: RTL and testbench
=========================================

SYNCHRONOUS_FIFO_FLAGS -- requirements
Module: synchronous_fifo_flags

Interface
REQ-001 SHALL have parameter DEPTH, default 8: number of entries; power of two, >= 4.
REQ-002 SHALL have parameter DATA_WIDTH, default 8: width of each entry in bits.
REQ-003 SHALL have parameter AFULL_LVL, default DEPTH-2: almost_full asserts when count >= AFULL_LVL; legal range 1..DEPTH.
REQ-004 SHALL have parameter AEMPTY_LVL, default 2: almost_empty asserts when count <= AEMPTY_LVL; legal range 0..DEPTH-1.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-007 SHALL have port w_en, input, 1 bit: write request.
REQ-008 SHALL have port r_en, input, 1 bit: read request.
REQ-009 SHALL have port clr_err, input, 1 bit: clears the sticky error flags.
REQ-010 SHALL have port data_in, input, DATA_WIDTH bits: write data.
REQ-011 SHALL have port data_out, output, DATA_WIDTH bits: registered read data.
REQ-012 SHALL have port full, output, 1 bit: FIFO holds DEPTH entries.
REQ-013 SHALL have port empty, output, 1 bit: FIFO holds 0 entries.
REQ-014 SHALL have port almost_full, output, 1 bit: count >= AFULL_LVL.
REQ-015 SHALL have port almost_empty, output, 1 bit: count <= AEMPTY_LVL.
REQ-016 SHALL have port count, output, $clog2(DEPTH)+1 bits: current occupancy, 0..DEPTH.
REQ-017 SHALL have port overflow, output, 1 bit: sticky flag for a rejected write.
REQ-018 SHALL have port underflow, output, 1 bit: sticky flag for a rejected read.

Function
REQ-019 SHALL use read and write pointers of $clog2(DEPTH)+1 bits, with the extra MSB as wrap indicator; low bits index the storage.
REQ-020 SHALL decode flags from the pointers: empty = pointers equal; full = MSBs differ and low bits equal.
REQ-021 SHALL accept a read (rd_ok) when r_en=1 and empty=0.
REQ-022 SHALL accept a write (wr_ok) when w_en=1 and either full=0 or rd_ok=1; writing while full is legal only together with an accepted read.
REQ-023 SHALL, on wr_ok, store data_in at the write address and increment the write pointer modulo 2*DEPTH.
REQ-024 SHALL, on rd_ok, load data_out from the read address at the same edge (1-cycle latency) and increment the read pointer modulo 2*DEPTH.
REQ-025 SHALL hold data_out when no read is accepted.
REQ-026 SHALL update count at each edge by +1 for wr_ok only, -1 for rd_ok only, and 0 when both or neither occur.
REQ-027 SHALL drive full, empty, almost_full and almost_empty as functions of registered state only, with no combinational path from inputs.
REQ-028 SHALL, when the FIFO is empty and w_en=r_en=1, accept the write, reject the read, and set underflow.
REQ-029 SHALL set overflow at the edge when w_en=1 and wr_ok=0; storage, pointers and count stay unchanged.
REQ-030 SHALL set underflow at the edge when r_en=1 and rd_ok=0; pointers, count and data_out stay unchanged.
REQ-031 SHALL clear both sticky flags on clr_err=1; a new error in the same cycle takes priority, so the flag stays set.
REQ-032 SHALL wrap the pointers through the full 2*DEPTH range without corrupting flag decode.

Reset
REQ-033 SHALL, on rst=1 at a rising edge, set both pointers to 0, count=0, data_out=0, empty=1, full=0, almost_full=0, almost_empty=1, overflow=0, underflow=0.
REQ-034 SHALL give rst priority over w_en, r_en and clr_err, including mid-operation; storage contents need not be cleared.
REQ-035 SHALL perform no write, read or flag update in any cycle where rst=1.

Verification (DEPTH=8, DATA_WIDTH=8, AFULL_LVL=6, AEMPTY_LVL=2)
REQ-036 SHALL cover: reset, then 8 writes of 0x11..0x88 -> count steps 1..8; almost_empty drops at count=3; almost_full rises at 6; full=1 at 8.
REQ-037 SHALL cover: 9th write (0x99) while full -> overflow=1, count=8; subsequent 8 reads return 0x11..0x88, each one cycle after r_en; empty=1.
REQ-038 SHALL cover: read while empty -> underflow=1, data_out holds 0x88; clr_err pulse -> both flags 0.
REQ-039 SHALL cover: FIFO full with w_en=r_en=1 for 1 cycle -> count stays 8, oldest word read, new word appended, no overflow.
REQ-040 SHALL cover: FIFO empty with w_en=r_en=1 -> count=1, underflow=1; then 20 cycles of simultaneous read/write at count=4 -> pointers wrap, data order preserved, count constant.
REQ-041 SHALL cover: rst asserted at count=5 with w_en=1 -> next cycle count=0, empty=1, data_out=0, flags cleared.

Source files
------------

// File: rtl/synchronous_fifo_flags.sv
// Purpose: single-clock FIFO with occupancy count, almost/full/empty flags and sticky error flags.
// Latency: a write is visible one edge later; data_out is loaded on the edge that accepts a read.
// Backpressure: writes are refused when full (unless a read is accepted at the same edge), reads are refused when empty; each refusal sets a sticky error flag.
module synchronous_fifo_flags #(
    parameter int DEPTH      = 8,
    parameter int DATA_WIDTH = 8,
    parameter int AFULL_LVL  = DEPTH - 2,
    parameter int AEMPTY_LVL = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       w_en,
    input  logic                       r_en,
    input  logic                       clr_err,
    input  logic [DATA_WIDTH-1:0]      data_in,
    output logic [DATA_WIDTH-1:0]      data_out,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow
);

    // Address width indexes the storage; pointers carry one extra wrap bit.
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    // Thresholds sized to the count register so comparisons stay width-matched.
    localparam logic [PW-1:0] AFULL_THR  = PW'(AFULL_LVL);
    localparam logic [PW-1:0] AEMPTY_THR = PW'(AEMPTY_LVL);
    localparam logic [PW-1:0] PTR_ONE    = PW'(1);

    // Storage array; contents are not reset, only the pointers are.
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Registered state.
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         count_q;
    logic [DATA_WIDTH-1:0] data_out_q;
    logic                  overflow_q;
    logic                  underflow_q;

    // Next-state values.
    logic [PW-1:0]         wr_ptr_nxt;
    logic [PW-1:0]         rd_ptr_nxt;
    logic [PW-1:0]         count_nxt;
    logic                  overflow_nxt;
    logic                  underflow_nxt;

    // Handshake qualifiers.
    logic                  rd_ok;
    logic                  wr_ok;
    logic                  wr_rejected;
    logic                  rd_rejected;

    // Split pointers into wrap bit and storage address.
    logic                  wr_wrap;
    logic                  rd_wrap;
    logic [AW-1:0]         wr_addr;
    logic [AW-1:0]         rd_addr;

    assign wr_wrap = wr_ptr[AW];
    assign rd_wrap = rd_ptr[AW];
    assign wr_addr = wr_ptr[AW-1:0];
    assign rd_addr = rd_ptr[AW-1:0];

    // Status decode uses registered state only, so no input reaches a flag combinationally.
    always_comb begin
        empty        = (wr_ptr == rd_ptr);
        full         = (wr_wrap != rd_wrap) && (wr_addr == rd_addr);
        almost_full  = (count_q >= AFULL_THR);
        almost_empty = (count_q <= AEMPTY_THR);
    end

    // Accept decisions: a write into a full FIFO is allowed only when a read frees a slot this edge.
    always_comb begin
        rd_ok       = r_en && !empty;
        wr_ok       = w_en && (!full || rd_ok);
        wr_rejected = w_en && !wr_ok;
        rd_rejected = r_en && !rd_ok;
    end

    // Pointer and occupancy next-state; pointers wrap naturally through 2*DEPTH.
    always_comb begin
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        count_nxt  = count_q;
        if (wr_ok) begin
            wr_ptr_nxt = wr_ptr + PTR_ONE;
        end
        if (rd_ok) begin
            rd_ptr_nxt = rd_ptr + PTR_ONE;
        end
        if (wr_ok && !rd_ok) begin
            count_nxt = count_q + PTR_ONE;
        end else if (rd_ok && !wr_ok) begin
            count_nxt = count_q - PTR_ONE;
        end
    end

    // Sticky error next-state: a fresh error wins over a clear in the same cycle.
    always_comb begin
        overflow_nxt  = overflow_q;
        underflow_nxt = underflow_q;
        if (clr_err) begin
            overflow_nxt  = 1'b0;
            underflow_nxt = 1'b0;
        end
        if (wr_rejected) begin
            overflow_nxt = 1'b1;
        end
        if (rd_rejected) begin
            underflow_nxt = 1'b1;
        end
    end

    // Storage write; suppressed while reset is asserted.
    always_ff @(posedge clk) begin
        if (!rst && wr_ok) begin
            mem[wr_addr] <= data_in;
        end
    end

    // Pointers, count and read data register; reset has priority over all requests.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            data_out_q <= '0;
        end else begin
            wr_ptr  <= wr_ptr_nxt;
            rd_ptr  <= rd_ptr_nxt;
            count_q <= count_nxt;
            if (rd_ok) begin
                data_out_q <= mem[rd_addr];
            end
        end
    end

    // Sticky error flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_nxt;
            underflow_q <= underflow_nxt;
        end
    end

    assign data_out  = data_out_q;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_synchronous_fifo_flags.sv
// Purpose: self-checking bench for synchronous_fifo_flags against a queue-based reference.
// Latency: every step advances one clock and compares all outputs 1 ns after the edge.
// Backpressure: refused writes/reads are predicted from queue occupancy.
module tb_synchronous_fifo_flags;

    localparam int DEPTH      = 8;
    localparam int DATA_WIDTH = 8;
    localparam int AFULL_LVL  = 6;
    localparam int AEMPTY_LVL = 2;
    localparam int CW         = $clog2(DEPTH) + 1;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  w_en = 1'b0;
    logic                  r_en = 1'b0;
    logic                  clr_err = 1'b0;
    logic [DATA_WIDTH-1:0] data_in = '0;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [CW-1:0]         count;
    logic                  overflow;
    logic                  underflow;

    synchronous_fifo_flags #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .AFULL_LVL  (AFULL_LVL),
        .AEMPTY_LVL (AEMPTY_LVL)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .w_en         (w_en),
        .r_en         (r_en),
        .clr_err      (clr_err),
        .data_in      (data_in),
        .data_out     (data_out),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    // Reference model: queue contents, last read word and sticky flags.
    logic [DATA_WIDTH-1:0] mq [$];
    logic [DATA_WIDTH-1:0] m_dout = '0;
    bit                    m_ovf = 1'b0;
    bit                    m_unf = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    // Compare every DUT output with the model.
    task automatic check_all(input string tag);
        int sz;
        sz = mq.size();
        chk({tag, ":count"},        32'(count),        32'(sz));
        chk({tag, ":empty"},        32'(empty),        32'(sz == 0));
        chk({tag, ":full"},         32'(full),         32'(sz == DEPTH));
        chk({tag, ":almost_full"},  32'(almost_full),  32'(sz >= AFULL_LVL));
        chk({tag, ":almost_empty"}, 32'(almost_empty), 32'(sz <= AEMPTY_LVL));
        chk({tag, ":data_out"},     32'(data_out),     32'(m_dout));
        chk({tag, ":overflow"},     32'(overflow),     32'(m_ovf));
        chk({tag, ":underflow"},    32'(underflow),    32'(m_unf));
    endtask

    // One clock: drive inputs, advance, update model from the queue rules, compare.
    task automatic step(input string tag, input bit rs, input bit w, input bit r,
                        input bit c, input logic [DATA_WIDTH-1:0] d);
        bit rd_ok;
        bit wr_ok;
        rst     = rs;
        w_en    = w;
        r_en    = r;
        clr_err = c;
        data_in = d;
        @(posedge clk);
        #1;
        if (rs) begin
            mq.delete();
            m_dout = '0;
            m_ovf  = 1'b0;
            m_unf  = 1'b0;
        end else begin
            rd_ok = r && (mq.size() > 0);
            wr_ok = w && ((mq.size() < DEPTH) || rd_ok);
            if (rd_ok) m_dout = mq.pop_front();
            if (wr_ok) mq.push_back(d);
            if (c) begin
                m_ovf = 1'b0;
                m_unf = 1'b0;
            end
            if (w && !wr_ok) m_ovf = 1'b1;
            if (r && !rd_ok) m_unf = 1'b1;
        end
        check_all(tag);
        rst     = 1'b0;
        w_en    = 1'b0;
        r_en    = 1'b0;
        clr_err = 1'b0;
    endtask

    initial begin
        logic [DATA_WIDTH-1:0] v;
        logic [DATA_WIDTH-1:0] k;

        // Reset state.
        step("reset", 1, 0, 0, 0, 8'h00);
        chk("reset_count_zero", 32'(count), 32'd0);
        chk("reset_empty", 32'(empty), 32'd1);
        chk("reset_almost_empty", 32'(almost_empty), 32'd1);

        // Fill with 0x11..0x88.
        for (int i = 1; i <= 8; i++) begin
            v = 8'(i * 17);
            step("fill", 0, 1, 0, 0, v);
            chk("fill_count", 32'(count), 32'(i));
        end
        chk("full_at_8", 32'(full), 32'd1);

        // Write while full is refused.
        step("overflow", 0, 1, 0, 0, 8'h99);
        chk("overflow_set", 32'(overflow), 32'd1);
        chk("overflow_count", 32'(count), 32'd8);

        // Drain: each word appears on the edge that accepts its read.
        for (int i = 1; i <= 8; i++) begin
            step("drain", 0, 0, 1, 0, 8'h00);
            k = 8'(i * 17);
            chk("drain_order", 32'(data_out), 32'(k));
        end
        chk("drained_empty", 32'(empty), 32'd1);

        // Read while empty: underflow, data_out holds.
        step("underflow", 0, 0, 1, 0, 8'h00);
        chk("underflow_hold", 32'(data_out), 32'h88);
        step("clr_err", 0, 0, 0, 1, 8'h00);
        chk("clr_ovf", 32'(overflow), 32'd0);
        chk("clr_unf", 32'(underflow), 32'd0);

        // Full with simultaneous read and write.
        for (int i = 0; i < 8; i++) step("refill", 0, 1, 0, 0, 8'(8'hA0 + i));
        step("full_rw", 0, 1, 1, 0, 8'hC5);
        chk("full_rw_count", 32'(count), 32'd8);
        chk("full_rw_oldest", 32'(data_out), 32'hA0);
        chk("full_rw_no_ovf", 32'(overflow), 32'd0);
        for (int i = 0; i < 8; i++) step("drain2", 0, 0, 1, 0, 8'h00);
        chk("full_rw_appended", 32'(data_out), 32'hC5);

        // Empty with simultaneous read and write, error cleared the same cycle still sets.
        step("empty_rw", 0, 1, 1, 1, 8'h3C);
        chk("empty_rw_count", 32'(count), 32'd1);
        chk("empty_rw_unf", 32'(underflow), 32'd1);
        for (int i = 0; i < 3; i++) step("to4", 0, 1, 0, 0, 8'(8'h40 + i));
        for (int i = 0; i < 20; i++) step("wrap_rw", 0, 1, 1, 0, 8'(8'h50 + i));
        chk("wrap_count", 32'(count), 32'd4);

        // Reset mid-operation with a write pending.
        step("clr", 0, 0, 0, 1, 8'h00);
        step("rst_mid", 1, 1, 0, 0, 8'hEE);
        for (int i = 0; i < 5; i++) step("to5", 0, 1, 0, 0, 8'(8'h60 + i));
        chk("pre_rst_count", 32'(count), 32'd5);
        step("rst_at5", 1, 1, 0, 0, 8'h77);
        chk("rst_at5_count", 32'(count), 32'd0);
        chk("rst_at5_dout", 32'(data_out), 32'd0);

        // Randomized traffic with drifting read/write bias, occasional clear and reset.
        for (int i = 0; i < 1500; i++) begin
            int wb;
            wb = ((i / 100) % 2 == 0) ? 70 : 30;
            step("rand", ($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 99) < wb),
                 ($urandom_range(0, 99) < (100 - wb)),
                 ($urandom_range(0, 15) == 0),
                 8'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
